// File: rtl/pulsadores_crono_if.sv
// Button-side bundle of the push-button conditioning stage.
// The master drives the raw buttons and the programming-mode enable.
// The slave returns the single-cycle command pulses to the chronometer.
interface pulsadores_crono_if;
  logic btn_arriba_in;
  logic btn_abajo_in;
  logic btn_izquierda_in;
  logic btn_derecha_in;
  logic btn_inicio_in;
  logic habilitar;
  logic arriba;
  logic abajo;
  logic izquierda;
  logic derecha;
  logic PushInicioCrono;

  modport master (
    output btn_arriba_in, btn_abajo_in, btn_izquierda_in, btn_derecha_in,
           btn_inicio_in, habilitar,
    input  arriba, abajo, izquierda, derecha, PushInicioCrono
  );

  modport slave (
    input  btn_arriba_in, btn_abajo_in, btn_izquierda_in, btn_derecha_in,
           btn_inicio_in, habilitar,
    output arriba, abajo, izquierda, derecha, PushInicioCrono
  );
endinterface

// File: rtl/pulsadores_crono.sv
// Push-button conditioning for the chronometer.
// Each raw button is synchronised, debounced and edge-detected into a
// one-cycle press pulse. Up and down also auto-repeat while held.
//
// Repeat FSM states (one FSM each for up and down):
//   state  | meaning
//   S_IDLE | no press pending; wait for a debounced press while enabled
//   S_WAIT | press seen; counting the initial delay before the first repeat
//   S_REP  | repeating; one pulse per repeat period while still held
//
// Button index map: 0 up, 1 down, 2 left, 3 right, 4 start.
module pulsadores_crono #(
  parameter int DEB_CYC = 1000000,
  parameter int REP_DLY = 50000000,
  parameter int REP_PER = 20000000
) (
  input  logic              clk,
  input  logic              Reset,
  pulsadores_crono_if.slave bus
);

  localparam int DW   = $clog2(DEB_CYC + 1);
  localparam int RMAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_REP  = 2'd2;

  // Counters are loaded with N-1 so that the pulse registers exactly N
  // cycles after the load edge.
  localparam logic [RW-1:0] DLY_LD = RW'(REP_DLY - 1);
  localparam logic [RW-1:0] PER_LD = RW'(REP_PER - 1);
  localparam logic [DW-1:0] DEB_TC = DW'(DEB_CYC);

  logic [4:0]    raw;
  logic [4:0]    sync1_q, sync2_q;
  logic [4:0]    deb_q, deb_d;
  logic [4:0]    deb_dly_q;
  logic [DW-1:0] deb_cnt_q [5];
  logic [DW-1:0] deb_cnt_d [5];
  logic [4:0]    press;

  logic [1:0]    st_q   [2];
  logic [1:0]    st_d   [2];
  logic [RW-1:0] rcnt_q [2];
  logic [RW-1:0] rcnt_d [2];
  logic [1:0]    fire;

  logic [4:0]    out_q, out_d;
  logic          hab;

  assign raw = {bus.btn_inicio_in, bus.btn_derecha_in, bus.btn_izquierda_in,
                bus.btn_abajo_in, bus.btn_arriba_in};
  assign hab = bus.habilitar;

  // Two-stage synchroniser on every raw button.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive disagreeing cycles, flip on reaching DEB_CYC.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 5; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_TC) begin
          deb_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Debounced state, its one-cycle delayed copy and the debounce counters.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      deb_q     <= '0;
      deb_dly_q <= '0;
      for (int i = 0; i < 5; i++) deb_cnt_q[i] <= '0;
    end else begin
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      for (int i = 0; i < 5; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  assign press = deb_q & ~deb_dly_q;

  // Auto-repeat next state for up and down; a press while disabled is lost.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      st_d[j]   = st_q[j];
      rcnt_d[j] = rcnt_q[j];
      fire[j]   = 1'b0;
      if (!hab) begin
        st_d[j]   = S_IDLE;
        rcnt_d[j] = '0;
      end else begin
        case (st_q[j])
          S_IDLE: begin
            if (press[j]) begin
              st_d[j]   = S_WAIT;
              rcnt_d[j] = DLY_LD;
            end
          end
          S_WAIT, S_REP: begin
            if (!deb_q[j]) begin
              st_d[j]   = S_IDLE;
              rcnt_d[j] = '0;
            end else if (rcnt_q[j] == '0) begin
              fire[j]   = 1'b1;
              st_d[j]   = S_REP;
              rcnt_d[j] = PER_LD;
            end else begin
              rcnt_d[j] = rcnt_q[j] - RW'(1);
            end
          end
          default: begin
            st_d[j]   = S_IDLE;
            rcnt_d[j] = '0;
          end
        endcase
      end
    end
  end

  // Repeat FSM state and counter registers.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int j = 0; j < 2; j++) begin
        st_q[j]   <= S_IDLE;
        rcnt_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        st_q[j]   <= st_d[j];
        rcnt_q[j] <= rcnt_d[j];
      end
    end
  end

  // Direction pulses are gated and prioritised up > down > left > right;
  // the start pulse bypasses both.
  always_comb begin
    out_d    = '0;
    out_d[0] = hab & (press[0] | fire[0]);
    out_d[1] = hab & (press[1] | fire[1]) & ~out_d[0];
    out_d[2] = hab & press[2] & ~out_d[0] & ~out_d[1];
    out_d[3] = hab & press[3] & ~out_d[0] & ~out_d[1] & ~out_d[2];
    out_d[4] = press[4];
  end

  // Registered command pulses.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) out_q <= '0;
    else        out_q <= out_d;
  end

  assign bus.arriba          = out_q[0];
  assign bus.abajo           = out_q[1];
  assign bus.izquierda       = out_q[2];
  assign bus.derecha         = out_q[3];
  assign bus.PushInicioCrono = out_q[4];

endmodule

// File: doc/pulsadores_crono.md
Name: pulsadores_crono

Overview:
- Push-button conditioning stage directly upstream of the chronometer/timer machine (MaquinaCrono).
- Takes five raw board buttons: up, down, left, right and start.
- Synchronises and debounces them, then produces the single-cycle command pulses arriba, abajo, izquierda, derecha and PushInicioCrono that the chronometer consumes.
- Provides auto-repeat on arriba/abajo so a held button steps the programmed value continuously.

Parameters:
- DEB_CYC, 1000000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
- REP_DLY, 50000000: cycles from press pulse to first auto-repeat pulse (500 ms).
- REP_PER, 20000000: cycles between subsequent auto-repeat pulses (200 ms).

Ports:
- clk  in  1  system clock, single clock domain.
- Reset  in  1  asynchronous, active-low reset.
- btn_arriba_in  in  1  raw up button, asynchronous, bouncy.
- btn_abajo_in  in  1  raw down button.
- btn_izquierda_in  in  1  raw left button.
- btn_derecha_in  in  1  raw right button.
- btn_inicio_in  in  1  raw start button.
- habilitar  in  1  programming mode (driven from ProgramarCrono); gates direction outputs.
- arriba  out  1  one-cycle up pulse, press plus auto-repeat.
- abajo  out  1  one-cycle down pulse, press plus auto-repeat.
- izquierda  out  1  one-cycle left pulse, press only.
- derecha  out  1  one-cycle right pulse, press only.
- PushInicioCrono  out  1  one-cycle start pulse, press only.

Behaviour:
- Reset low, asynchronous: all five outputs 0; synchronisers, debounced states, debounce counters, repeat counters and FSMs all cleared. Debounced state = released.
- Synchronisation: each raw input passes through a 2-FF synchroniser before any other logic.
- Debounce, per button:
  - Counter of width $clog2(DEB_CYC+1).
  - Counter increments while the synced level differs from the debounced state.
  - Counter clears to 0 on any cycle the two agree, so a bounce restarts the count.
  - When the count reaches DEB_CYC, the debounced state flips and the counter clears.
- Press latency:
  - Raw input held high from sample edge E gives its press pulse registered high for exactly one cycle at edge E+DEB_CYC+3.
  - Release produces no pulse.
- Auto-repeat FSM, per arriba/abajo: IDLE -> WAIT -> REP.
  - IDLE -> WAIT on press pulse; repeat counter loaded.
  - WAIT -> REP after REP_DLY cycles, emitting one pulse.
  - In REP, one pulse every REP_PER cycles.
  - Any state -> IDLE on debounced release, or habilitar=0.
- izquierda, derecha and PushInicioCrono never repeat.
- habilitar gating:
  - habilitar=0 forces arriba/abajo/izquierda/derecha to 0 and holds both repeat FSMs in IDLE.
  - PushInicioCrono is not gated.
  - A press debounced while habilitar=0 is consumed. If habilitar rises while that button is still held, no pulse occurs until release and re-press.
- Simultaneous events: at most one direction output is high per cycle.
  - Priority: arriba > abajo > izquierda > derecha.
  - Losing pulses are dropped, not queued.
  - PushInicioCrono is independent and may coincide with a direction pulse.
- Reset mid-operation:
  - Outputs drop immediately; repeat sequences are abandoned.
  - A button still held at Reset release is treated as a new press and pulses DEB_CYC+3 edges after release.
- Counter arithmetic: repeat counters sized $clog2(max(REP_DLY,REP_PER)+1), saturating compare, no wrap-around.

Test Plan (override DEB_CYC=4, REP_DLY=16, REP_PER=8):
1. Reset low 3 cycles, then high with all buttons low -> all outputs 0 for 50 cycles.
2. habilitar=1; btn_izquierda_in high from edge 10 for 20 cycles -> izquierda high only at edge 17; no further pulses, nothing on release.
3. habilitar=1; btn_arriba_in toggled every 2 cycles for 12 cycles, then held high from edge 30 for 50 cycles:
   - No pulse during toggling.
   - arriba at edges 37, 53, 61, 69, 77.
   - After release, no more pulses.
4. habilitar=1; btn_abajo_in and btn_derecha_in rise on the same edge and are held -> abajo pulses at +7; derecha stays 0 throughout; abajo repeats at +23, +31.
5. habilitar=0; btn_arriba_in and btn_inicio_in rise together, held 30 cycles:
   - PushInicioCrono pulses once at +7; arriba stays 0.
   - Raising habilitar mid-hold -> still no arriba.
   - Release, then re-press -> arriba pulses at re-press +7.
6. btn_arriba_in held with habilitar=1; Reset pulsed low during REP state:
   - arriba drops immediately.
   - Reset released with button still high -> single arriba at release+7, repeats resume at release+23.
